// File: rtl/encoder_spi_resp.sv
// Encoder-side SPI responder: step/dir position counter, snapshot on cs request, framed serial reply on miso.
// Optional macro ENC_RESP_CRC_EN appends an inverted 6-bit CRC (x^6+x+1, seed 0) after the status bits.
module encoder_spi_resp #(
    parameter int POS_W       = 12,
    parameter int ACK_CYC     = 2,
    parameter int TIMEOUT_CYC = 4
) (
    input  logic             sck,
    input  logic             rst,
    input  logic             cs,
    output logic             miso,
    input  logic             step,
    input  logic             dir,
    input  logic             pos_load,
    input  logic [POS_W-1:0] pos_load_val,
    input  logic             err_in,
    input  logic             warn_in,
    output logic             busy,
    output logic             frame_done,
    output logic [POS_W-1:0] pos
);

`ifdef ENC_RESP_CRC_EN
    localparam int FRAME_W = POS_W + 8;
`else
    localparam int FRAME_W = POS_W + 2;
`endif
    localparam int CNT_MAX0 = (ACK_CYC > TIMEOUT_CYC) ? ACK_CYC : TIMEOUT_CYC;
    localparam int CNT_MAX  = (FRAME_W > CNT_MAX0) ? FRAME_W : CNT_MAX0;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, ACK, START, DATA, TIMEOUT} state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt, cnt_nx;
    logic [FRAME_W-1:0]   shift, shift_nx;
    logic [FRAME_W-1:0]   frame_word;
    logic                 miso_nx;
    logic [POS_W+1:0]     payload;

    assign payload = {pos, ~err_in, ~warn_in};

`ifdef ENC_RESP_CRC_EN
    function automatic logic [5:0] crc6(input logic [POS_W+1:0] msg);
        logic [5:0] c;
        logic       fb;
        c = '0;
        for (int i = POS_W + 1; i >= 0; i--) begin
            fb = c[5] ^ msg[i];
            c  = {c[4:0], 1'b0};
            if (fb) c = c ^ 6'h03;
        end
        return c;
    endfunction

    assign frame_word = {payload, ~crc6(payload)};
`else
    assign frame_word = payload;
`endif

    // Counter keeps running in every state; the snapshot takes the value before this cycle's update.
    always_ff @(posedge sck) begin
        if (rst)
            pos <= '0;
        else if (pos_load)
            pos <= pos_load_val;
        else if (step)
            pos <= dir ? pos - POS_W'(1) : pos + POS_W'(1);
    end

    always_ff @(posedge sck) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            shift <= '0;
            miso  <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            shift <= shift_nx;
            miso  <= miso_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shift_nx = shift;
        miso_nx  = 1'b1;
        case (state)
            IDLE: begin
                if (!cs) begin
                    state_nx = ACK;
                    cnt_nx   = CNT_W'(ACK_CYC - 1);
                    shift_nx = frame_word;
                end
            end
            ACK: begin
                miso_nx = 1'b0;
                if (cnt == '0) state_nx = START;
                else           cnt_nx   = cnt - CNT_W'(1);
            end
            START: begin
                state_nx = DATA;
                cnt_nx   = CNT_W'(FRAME_W - 1);
            end
            DATA: begin
                miso_nx  = shift[FRAME_W-1];
                shift_nx = {shift[FRAME_W-2:0], 1'b0};
                if (cnt == '0) begin
                    state_nx = TIMEOUT;
                    cnt_nx   = CNT_W'(TIMEOUT_CYC - 1);
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            TIMEOUT: begin
                miso_nx = 1'b0;
                if (cnt == '0) state_nx = IDLE;
                else           cnt_nx   = cnt - CNT_W'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == TIMEOUT) && (cnt == '0);

endmodule

// File: tb/tb_encoder_spi_resp.sv
// Self-checking bench for encoder_spi_resp; expected miso/busy/frame_done per cycle queued in a scoreboard.
module tb_encoder_spi_resp;

    localparam int POS_W       = 12;
    localparam int ACK_CYC     = 2;
    localparam int TIMEOUT_CYC = 4;
`ifdef ENC_RESP_CRC_EN
    localparam int FRAME_W = POS_W + 8;
`else
    localparam int FRAME_W = POS_W + 2;
`endif
    localparam int BUSY_LEN = ACK_CYC + 1 + FRAME_W + TIMEOUT_CYC;

    logic             sck = 1'b0;
    logic             rst, cs, miso, step, dir, pos_load, err_in, warn_in, busy, frame_done;
    logic [POS_W-1:0] pos_load_val, pos;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic miso;
        logic busy;
        logic fd;
    } exp_t;
    exp_t exp_q[$];

    encoder_spi_resp #(.POS_W(POS_W), .ACK_CYC(ACK_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .sck(sck), .rst(rst), .cs(cs), .miso(miso), .step(step), .dir(dir),
        .pos_load(pos_load), .pos_load_val(pos_load_val), .err_in(err_in), .warn_in(warn_in),
        .busy(busy), .frame_done(frame_done), .pos(pos)
    );

    always #5 sck = ~sck;

    task automatic cyc();
        @(posedge sck);
        #1;
    endtask

    // Golden frame: payload, then (optionally) the inverted CRC6 computed by polynomial long division.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [POS_W-1:0] p, input logic ne, input logic nw);
        logic [POS_W+1:0] m;
        m = {p, ne, nw};
`ifdef ENC_RESP_CRC_EN
        begin
            logic [POS_W+7:0] r;
            r = {m, 6'b0};
            for (int i = POS_W + 7; i >= 6; i--)
                if (r[i]) r[i -: 7] = r[i -: 7] ^ 7'b1000011;
            return {m, ~r[5:0]};
        end
`else
        return m;
`endif
    endfunction

    task automatic push_frame(input logic [FRAME_W-1:0] fr);
        exp_t e;
        for (int k = 0; k <= BUSY_LEN + 1; k++) begin
            if (k == 0)                       e.miso = 1'b1;
            else if (k <= ACK_CYC)            e.miso = 1'b0;
            else if (k == ACK_CYC + 1)        e.miso = 1'b1;
            else if (k <= ACK_CYC + 1 + FRAME_W) e.miso = fr[FRAME_W-1-(k-ACK_CYC-2)];
            else if (k <= BUSY_LEN)           e.miso = 1'b0;
            else                              e.miso = 1'b1;
            e.busy = (k < BUSY_LEN);
            e.fd   = (k == BUSY_LEN - 1);
            exp_q.push_back(e);
        end
    endtask

    // Pops one expectation per cycle starting right after the request edge; optional cs glitch at sample cs_k.
    task automatic check_frame(input string name, input int cs_k);
        exp_t e;
        for (int k = 0; k <= BUSY_LEN + 1; k++) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL %s scoreboard empty at k=%0d", name, k);
                break;
            end
            e = exp_q.pop_front();
            total++;
            if ({miso, busy, frame_done} !== {e.miso, e.busy, e.fd}) begin
                bad++;
                $display("FAIL %s k=%0d miso/busy/done got %b%b%b want %b%b%b",
                         name, k, miso, busy, frame_done, e.miso, e.busy, e.fd);
            end
            if (k == cs_k) cs = 1'b0;
            if (k < BUSY_LEN + 1) cyc();
            cs = 1'b1;
        end
    endtask

    task automatic request();
        cs = 1'b0;
        cyc();
        cs = 1'b1;
    endtask

    task automatic check_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            total++;
            if (miso !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
                bad++;
                $display("FAIL %s idle cycle %0d miso/busy/done got %b%b%b want 100",
                         name, i, miso, busy, frame_done);
            end
            cyc();
        end
    endtask

    task automatic check_pos(input string name, input logic [POS_W-1:0] want);
        total++;
        if (pos !== want) begin
            bad++;
            $display("FAIL %s pos got %h want %h", name, pos, want);
        end
    endtask

    task automatic load(input logic [POS_W-1:0] v);
        pos_load = 1'b1; pos_load_val = v;
        cyc();
        pos_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        total++;
        if (miso !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || pos !== '0) begin
            bad++;
            $display("FAIL reset miso/busy/done/pos got %b%b%b/%h want 100/000", miso, busy, frame_done, pos);
        end
        rst = 1'b0;
        check_idle("reset_release", 10);
        check_pos("reset_release", '0);
    endtask

    task automatic test_position_read();
        for (int i = 0; i < 5; i++) begin
            step = 1'b1; dir = 1'b0;
            cyc();
        end
        step = 1'b0;
        check_pos("steps", 12'h005);
        push_frame(make_frame(12'h005, 1'b1, 1'b1));
        request();
        check_frame("read5", -1);
        check_idle("read5_after", 3);
    endtask

    task automatic test_wrap();
        load(12'hFFF);
        check_pos("load_fff", 12'hFFF);
        step = 1'b1; dir = 1'b0; cyc(); step = 1'b0;
        check_pos("wrap_up", 12'h000);
        step = 1'b1; dir = 1'b1; cyc(); step = 1'b0;
        check_pos("wrap_down", 12'hFFF);
        pos_load = 1'b1; pos_load_val = 12'h123; step = 1'b1; dir = 1'b0;
        cyc();
        pos_load = 1'b0; step = 1'b0;
        check_pos("load_beats_step", 12'h123);
    endtask

    task automatic test_snapshot_race();
        load(12'h007);
        err_in = 1'b1; warn_in = 1'b0;
        push_frame(make_frame(12'h007, 1'b0, 1'b1));
        cs = 1'b0; step = 1'b1; dir = 1'b0;
        cyc();
        cs = 1'b1; step = 1'b0;
        check_pos("race_pos", 12'h008);
        check_frame("race", -1);
        err_in = 1'b0; warn_in = 1'b0;
    endtask

    task automatic test_ignored_request();
        load(12'hA5C);
        push_frame(make_frame(12'hA5C, 1'b1, 1'b1));
        request();
        check_frame("ignored_cs", ACK_CYC + 6);
        check_idle("ignored_after", 4);
    endtask

    task automatic test_abort();
        load(12'h3C3);
        request();
        repeat (ACK_CYC + 6) cyc();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre busy got %b want 1", busy);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total++;
        if (miso !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort miso/busy got %b%b want 10", miso, busy);
        end
        check_pos("abort_pos", '0);
        check_idle("abort_after", 4);
    endtask

    task automatic test_crc_frame();
        load(12'h5A3);
        push_frame(make_frame(12'h5A3, 1'b1, 1'b1));
        request();
        check_frame("pos5a3", -1);
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; step = 1'b0; dir = 1'b0; pos_load = 1'b0;
        pos_load_val = '0; err_in = 1'b0; warn_in = 1'b0;
        #2;
        test_reset();
        test_position_read();
        test_wrap();
        test_snapshot_race();
        test_ignored_request();
        test_abort();
        test_crc_frame();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder_spi_resp.md
Name: encoder_spi_resp

Overview:
- Encoder-side SPI responder: the slave end of the position-read link that the encoder_spi master reads.
- Emulates an absolute rotary encoder for bring-up and closed-loop tests without hardware.
- Keeps an internal position counter driven by step/dir. On a cs request it snapshots the counter and status bits, then serialises a framed word on miso, clocked by sck.

Parameters:
- POS_W, 12, position width in bits; counter wraps modulo 2^POS_W.
- ACK_CYC, 2, cycles miso is held 0 after a request is accepted (>=1).
- TIMEOUT_CYC, 4, cycles miso is held 0 after the last data bit (>=1).

Ports:
- sck  in  1  clock, free-running; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- cs  in  1  request, active-low; sampled on posedge.
- miso  out  1  serial data to master; registered.
- step  in  1  advance position by one count this cycle.
- dir  in  1  0 = increment, 1 = decrement.
- pos_load  in  1  load pos_load_val into the counter; has priority over step.
- pos_load_val  in  POS_W  value for pos_load.
- err_in  in  1  error status; sent active-low as nE.
- warn_in  in  1  warning status; sent active-low as nW.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on the last TIMEOUT cycle.
- pos  out  POS_W  current counter value.

Behaviour:
- Interface: one clock, sck; synchronous active-high reset rst.
- Reset state: miso=1, busy=0, frame_done=0, pos=0, FSM=IDLE, all counters 0.
- rst asserted mid-frame: the frame is aborted; miso=1 and IDLE on the next posedge.
- Counter update, evaluated every cycle in every state:
  - pos_load -> pos_load_val;
  - else step&~dir -> pos+1;
  - else step&dir -> pos-1.
  - Wrap: max+1 -> 0 and 0-1 -> max.
- Frame contents, MSB first: pos[POS_W-1:0], nE=~err_in, nW=~warn_in. FRAME_W = POS_W+2, or POS_W+8 with CRC.

FSM:
- IDLE:
  - miso=1.
  - cs==0 sampled -> snapshot the pre-update pos plus nE/nW into the shift register, go to ACK.
  - A step or pos_load in the same cycle affects pos but not the snapshot.
- ACK: miso=0 for ACK_CYC cycles -> START.
- START: miso=1 for 1 cycle -> DATA.
- DATA: miso=shift MSB; shift left each cycle; after FRAME_W bits -> TIMEOUT.
- TIMEOUT:
  - miso=0 for TIMEOUT_CYC cycles.
  - frame_done=1 on the final cycle -> IDLE, where miso=1 on the next cycle.
- cs==0 outside IDLE is ignored: no restart and no queueing. A cs held low through the return to IDLE starts a new frame.
- Latency: first data bit (pos MSB) on miso at posedge 2+ACK_CYC after the request edge.
- Total busy length: ACK_CYC+1+FRAME_W+TIMEOUT_CYC cycles.

Optional Feature:
- Macro ENC_RESP_CRC_EN.
- Defined:
  - Append a 6-bit CRC after nW: polynomial x^6+x^1+1, seed 0, computed over pos,nE,nW MSB first.
  - Transmitted inverted, MSB first; FRAME_W = POS_W+8.
  - The CRC is computed serially during DATA or precomputed at snapshot; either way it is ready at bit POS_W+2.
- Undefined: no CRC bits; FRAME_W = POS_W+2; no CRC logic is synthesised.

Test Plan:
- Reset: hold rst 3 cycles -> miso=1, busy=0, pos=0; still so 10 cycles after release with cs=1.
- Position read:
  - 5 step pulses with dir=0, then cs low for 1 cycle.
  - miso = 0,0 | 1 | 000000000101 | 1,1 | 0,0,0,0 -> 1.
  - busy high for 21 cycles; frame_done pulses once.
- Wrap: pos_load_val=0xFFF, then step with dir=0 -> pos=0x000; step with dir=1 -> pos=0xFFF. pos_load and step in the same cycle -> loaded value wins.
- Snapshot race: pos=7, step with dir=0 in the same cycle as the cs request -> frame carries 7, pos becomes 8. err_in=1, warn_in=0 -> nE=0, nW=1.
- Ignored request and abort:
  - cs pulse during DATA -> frame unchanged, returns to IDLE with no second frame.
  - rst during DATA -> miso=1, busy=0 the next cycle.
- ENC_RESP_CRC_EN: frame for pos=0x5A3, nE=nW=1 -> 6 trailing bits equal the inverted output of a golden CRC6 model; busy spans 27 cycles.
